// File: rtl/fp_int_pkg.sv
// Shared constants and types for the FP-product to fixed-point accumulator path.
package fp_int_pkg;

  localparam int unsigned FP16_BIAS = 15;
  localparam int unsigned MANT_FRAC = 10;
  localparam int unsigned EXP_W     = 5;
  localparam int unsigned MANT_W    = 14;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/fp_int_acc_if.sv
// Config, product and result signals between the multiplier side and fp_int_acc.
interface fp_int_acc_if
  import fp_int_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned LEN_W     = 8
);

  logic                 set;
  logic [LEN_W-1:0]     len;
  logic                 start_acc;
  logic                 sign_in;
  logic [EXP_W-1:0]     exp_in;
  logic [MANT_W-1:0]    mant_in;
  logic                 flush;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 out_valid;
  logic                 busy;

  modport master (
    output set, len, start_acc, sign_in, exp_in, mant_in, flush,
    input  acc_out, out_valid, busy
  );

  modport slave (
    input  set, len, start_acc, sign_in, exp_in, mant_in, flush,
    output acc_out, out_valid, busy
  );

endinterface

// File: rtl/fp_int_align.sv
// Combinational shift/negate of an FP16-biased product into a signed fixed-point word.
// Exponent zero flushes to zero; right shifts truncate.
module fp_int_align
  import fp_int_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic                        sign,
  input  logic [EXP_W-1:0]            exponent,
  input  logic [MANT_W-1:0]           mant,
  output logic signed [ACC_WIDTH-1:0] value_c
);

  // Exponent at which the mantissa lands unshifted in the accumulator format.
  localparam int OFFSET = int'(FP16_BIAS + MANT_FRAC) - int'(FRAC_BITS);

  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH-1:0] mag;
  int                   sh;

  // Shift mantissa by the unbiased exponent distance, then apply the sign.
  always_comb begin
    ext = ACC_WIDTH'(mant);
    sh  = int'(exponent) - OFFSET;
    mag = '0;
    if (exponent == '0) begin
      mag = '0;
    end else if (sh >= 0) begin
      mag = ext << sh;
    end else begin
      mag = ext >> (-sh);
    end
    value_c = sign ? -signed'(mag) : signed'(mag);
  end

endmodule

// File: rtl/fp_int_acc.sv
// Align-and-accumulate stage behind the bit-serial FP multiplier.
// Sums LEN products per output, with flush and live reconfiguration.
// Build option: FP_INT_ACC_SAT_EN selects saturating adds instead of wrap-around.
module fp_int_acc
  import fp_int_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned LEN_W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  fp_int_acc_if.slave  bus
);

  fsm_state_t                  state, state_nxt;
  logic [LEN_W-1:0]            len_q, len_nxt;
  logic                        s1_valid, s1v_nxt;
  logic signed [ACC_WIDTH-1:0] s1_data, s1d_nxt;
  logic signed [ACC_WIDTH-1:0] acc, acc_nxt;
  logic [LEN_W-1:0]            count, cnt_nxt;
  logic                        flush_pend, fp_nxt;
  logic [ACC_WIDTH-1:0]        acc_out_q, out_nxt;
  logic                        out_valid_q, ov_nxt;
  logic                        busy_q, busy_nxt;

  logic signed [ACC_WIDTH-1:0] aligned_c;
  logic signed [ACC_WIDTH-1:0] sum_raw_c;
  logic signed [ACC_WIDTH-1:0] sum_c;
  logic [LEN_W-1:0]            len_eff_c;
  logic [LEN_W-1:0]            count_inc_c;
  logic                        accept_c;
  logic                        flush_hit_c;

  fp_int_align #(
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_align (
    .sign     (bus.sign_in),
    .exponent (bus.exp_in),
    .mant     (bus.mant_in),
    .value_c  (aligned_c)
  );

  // Stage-2 adder; saturates on signed overflow when enabled.
`ifdef FP_INT_ACC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic ovf_c;

  always_comb begin
    sum_raw_c = acc + s1_data;
    ovf_c     = (acc[ACC_WIDTH-1] == s1_data[ACC_WIDTH-1]) &&
                (sum_raw_c[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    if (ovf_c) begin
      sum_c = acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_c = sum_raw_c;
    end
  end
`else
  always_comb begin
    sum_raw_c = acc + s1_data;
    sum_c     = sum_raw_c;
  end
`endif

  // Qualifiers shared by the next-state logic.
  always_comb begin
    len_eff_c   = (len_q == '0) ? LEN_W'(1) : len_q;
    count_inc_c = LEN_W'(count + LEN_W'(1));
    accept_c    = (state == RUN) && bus.start_acc && !bus.set;
    flush_hit_c = (state == RUN) && bus.flush && !bus.set &&
                  ((count != '0) || s1_valid || accept_c);
  end

  // Run control, stage-1 capture, stage-2 accumulate and flush sequencing.
  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    s1v_nxt   = 1'b0;
    s1d_nxt   = s1_data;
    acc_nxt   = acc;
    cnt_nxt   = count;
    fp_nxt    = flush_pend;
    out_nxt   = acc_out_q;
    ov_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.set) begin
          state_nxt = RUN;
          len_nxt   = bus.len;
        end
      end
      RUN: begin
        if (bus.set) begin
          // Reconfigure: drop partial sum and in-flight product silently.
          len_nxt = bus.len;
          acc_nxt = '0;
          cnt_nxt = '0;
          fp_nxt  = 1'b0;
        end else begin
          s1v_nxt = accept_c;
          if (accept_c) begin
            s1d_nxt = aligned_c;
          end
          if (s1_valid) begin
            if (count_inc_c == len_eff_c) begin
              out_nxt = sum_c;
              ov_nxt  = 1'b1;
              acc_nxt = '0;
              cnt_nxt = '0;
              fp_nxt  = bus.flush && accept_c;
            end else begin
              acc_nxt = sum_c;
              cnt_nxt = count_inc_c;
              fp_nxt  = flush_pend || flush_hit_c;
            end
          end else if (flush_pend) begin
            // Pipeline drained: emit the partial sum.
            out_nxt = acc;
            ov_nxt  = 1'b1;
            acc_nxt = '0;
            cnt_nxt = '0;
            fp_nxt  = bus.flush && accept_c;
          end else begin
            fp_nxt = flush_hit_c;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = s1v_nxt || (cnt_nxt != '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      len_q       <= '0;
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      acc         <= '0;
      count       <= '0;
      flush_pend  <= 1'b0;
      acc_out_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      len_q       <= len_nxt;
      s1_valid    <= s1v_nxt;
      s1_data     <= s1d_nxt;
      acc         <= acc_nxt;
      count       <= cnt_nxt;
      flush_pend  <= fp_nxt;
      acc_out_q   <= out_nxt;
      out_valid_q <= ov_nxt;
      busy_q      <= busy_nxt;
    end
  end

  assign bus.acc_out   = acc_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fp_int_acc.sv
// Directed self-checking bench for fp_int_acc.
module tb_fp_int_acc;
  import fp_int_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   ov_cnt;
  int   ov_base;

  fp_int_acc_if #(.ACC_WIDTH(32), .LEN_W(8)) bus ();

  fp_int_acc #(
    .ACC_WIDTH (32),
    .FRAC_BITS (8),
    .LEN_W     (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every out_valid pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) ov_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_set(input logic [7:0] l);
    bus.set = 1'b1;
    bus.len = l;
    tick();
    bus.set = 1'b0;
  endtask

  task automatic prod(input logic s, input logic [4:0] e, input logic [13:0] m);
    bus.start_acc = 1'b1;
    bus.sign_in   = s;
    bus.exp_in    = e;
    bus.mant_in   = m;
    tick();
    bus.start_acc = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [31:0] exp, input int limit);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_valid"}, 64'(seen), 64'd1);
    check({tag, "_value"}, 64'(bus.acc_out), 64'(exp));
  endtask

  initial begin
    logic [31:0] ovf_exp;
    total = 0;
    bad = 0;
    ov_cnt = 0;
    rst = 1'b0;
    bus.set = 1'b0;
    bus.len = '0;
    bus.start_acc = 1'b0;
    bus.sign_in = 1'b0;
    bus.exp_in = '0;
    bus.mant_in = '0;
    bus.flush = 1'b0;

    tick();
    tick();
    check("rst_acc_out", 64'(bus.acc_out), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b1;
    tick();

    // Reset in the middle of a sum.
    do_set(8'd4);
    prod(1'b0, 5'd17, 14'd1);
    prod(1'b0, 5'd17, 14'd2);
    check("mid_busy", 64'(bus.busy), 64'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_acc_out", 64'(bus.acc_out), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    ov_base = ov_cnt;
    prod(1'b0, 5'd17, 14'd5);
    tick();
    tick();
    check("idle_ignore_busy", 64'(bus.busy), 64'd0);
    check("idle_ignore_ov", 64'(ov_cnt - ov_base), 64'd0);

    // Basic sum with exact latency.
    do_set(8'd3);
    prod(1'b0, 5'd17, 14'd100);
    prod(1'b0, 5'd18, 14'd3);
    prod(1'b1, 5'd17, 14'd50);
    check("basic_early", 64'(bus.out_valid), 64'd0);
    tick();
    check("basic_valid", 64'(bus.out_valid), 64'd1);
    check("basic_value", 64'(bus.acc_out), 64'd56);
    tick();
    check("basic_pulse", 64'(bus.out_valid), 64'd0);

    // Truncation and flush-to-zero.
    do_set(8'd2);
    prod(1'b0, 5'd16, 14'd5);
    prod(1'b0, 5'd0, 14'd9999);
    wait_out("trunc", 32'd2, 4);
    do_set(8'd1);
    prod(1'b1, 5'd1, 14'd16383);
    wait_out("tiny_neg", 32'd0, 4);

    // len=0 behaves as 1; flush with nothing pending is ignored.
    do_set(8'd0);
    prod(1'b0, 5'd17, 14'd7);
    wait_out("len0", 32'd7, 4);
    tick();
    ov_base = ov_cnt;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
    tick();
    tick();
    check("idle_flush_ov", 64'(ov_cnt - ov_base), 64'd0);

    // Flush a partial sum.
    do_set(8'd8);
    prod(1'b0, 5'd17, 14'd10);
    prod(1'b0, 5'd17, 14'd10);
    prod(1'b0, 5'd17, 14'd10);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    wait_out("flush", 32'd30, 6);

    // Flush together with start_acc includes that product.
    tick();
    do_set(8'd8);
    prod(1'b0, 5'd17, 14'd10);
    bus.flush = 1'b1;
    prod(1'b0, 5'd17, 14'd20);
    bus.flush = 1'b0;
    wait_out("flush_start", 32'd30, 6);

    // Reconfigure mid-sum: no output, next sum restarts from zero.
    tick();
    ov_base = ov_cnt;
    do_set(8'd8);
    prod(1'b0, 5'd17, 14'd10);
    prod(1'b0, 5'd17, 14'd10);
    do_set(8'd2);
    tick();
    tick();
    check("reset_sum_ov", 64'(ov_cnt - ov_base), 64'd0);
    check("reset_sum_busy", 64'(bus.busy), 64'd0);
    prod(1'b0, 5'd17, 14'd4);
    prod(1'b0, 5'd17, 14'd5);
    wait_out("restart", 32'd9, 4);

    // Overflow over nine maximal terms.
`ifdef FP_INT_ACC_SAT_EN
    ovf_exp = 32'h7FFF_FFFF;
`else
    ovf_exp = 32'h8FFD_C000;
`endif
    do_set(8'd9);
    for (int i = 0; i < 9; i++) begin
      prod(1'b0, 5'd31, 14'd16383);
    end
    wait_out("overflow", ovf_exp, 4);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
